csr_unit: RTL

Parametrised control/status register unit for the RISC-V core. It replaces the flat CSR RAM with decoded, individually implemented registers and full Zicsr semantics: CSRRW/CSRRS/CSRRC and their immediate forms, read-before-write. It adds free-running cycle and retired-instruction counters and a `tohost` register with a write strobe for the test harness. It sits in the execute stage next to the ALU; its read data goes to writeback like an ALU result.

---
 rtl/csr_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/csr_unit.sv
// Decoded Zicsr control/status register unit: mscratch, tohost with a write strobe,
// and free-running cycle/instret counters readable and writable as two halves.
module csr_unit #(
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        func,
    input  logic [11:0]       addr,
    input  logic [4:0]        rs1_idx,
    input  logic [DWIDTH-1:0] rs1_data,
    input  logic              retire,
    output logic [DWIDTH-1:0] data_out,
    output logic              illegal,
    output logic [DWIDTH-1:0] tohost,
    output logic              tohost_wr
);

    localparam int HW = CNT_WIDTH - DWIDTH;

    localparam logic [11:0] ADDR_TOHOST    = 12'h51E;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    logic [DWIDTH-1:0]    mscratch_r;
    logic [DWIDTH-1:0]    tohost_r;
    logic                 tohost_wr_r;
    logic [CNT_WIDTH-1:0] cycle_r;
    logic [CNT_WIDTH-1:0] instret_r;

    logic [DWIDTH-1:0]    opnd_s;
    logic [DWIDTH-1:0]    old_s;
    logic [DWIDTH-1:0]    wdata_s;
    logic                 hit_s;
    logic                 ro_s;
    logic                 op_valid_s;
    logic                 wr_req_s;
    logic                 wr_eff_s;
    logic                 wr_tohost_s;
    logic                 wr_mscratch_s;
    logic                 wr_mcycle_s;
    logic                 wr_mcycleh_s;
    logic                 wr_minstret_s;
    logic                 wr_minstreth_s;

    // Upper counter word, zero-extended to the datapath width.
    function automatic logic [DWIDTH-1:0] hi_word(input logic [CNT_WIDTH-1:0] cnt);
        logic [DWIDTH-1:0] w;
        w         = {DWIDTH{1'b0}};
        w[HW-1:0] = cnt[CNT_WIDTH-1:DWIDTH];
        return w;
    endfunction

    // Next counter value: a write to either half beats the increment, no carry that cycle.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 inc,
        input logic                 wr_lo,
        input logic                 wr_hi,
        input logic [DWIDTH-1:0]    wd
    );
        logic [CNT_WIDTH-1:0] n;
        n = cur;
        if (wr_lo) begin
            n[DWIDTH-1:0] = wd;
        end else if (wr_hi) begin
            n[CNT_WIDTH-1:DWIDTH] = wd[HW-1:0];
        end else if (inc) begin
            n = cur + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            n = cur;
        end
        return n;
    endfunction

    // Operand select, address decode, read-before-write value and write qualification.
    always_comb begin
        opnd_s     = func[2] ? {{(DWIDTH-5){1'b0}}, rs1_idx} : rs1_data;
        old_s      = {DWIDTH{1'b0}};
        hit_s      = 1'b0;
        ro_s       = 1'b0;
        op_valid_s = (func[1:0] != 2'b00);
        wr_req_s   = en && op_valid_s && ((func[1:0] == 2'b01) || (rs1_idx != 5'd0));

        case (addr)
            ADDR_TOHOST:    begin old_s = tohost_r;                  hit_s = 1'b1; end
            ADDR_MSCRATCH:  begin old_s = mscratch_r;                hit_s = 1'b1; end
            ADDR_MCYCLE:    begin old_s = cycle_r[DWIDTH-1:0];       hit_s = 1'b1; end
            ADDR_MCYCLEH:   begin old_s = hi_word(cycle_r);          hit_s = 1'b1; end
            ADDR_MINSTRET:  begin old_s = instret_r[DWIDTH-1:0];     hit_s = 1'b1; end
            ADDR_MINSTRETH: begin old_s = hi_word(instret_r);        hit_s = 1'b1; end
            ADDR_CYCLE:     begin old_s = cycle_r[DWIDTH-1:0];   hit_s = 1'b1; ro_s = 1'b1; end
            ADDR_CYCLEH:    begin old_s = hi_word(cycle_r);      hit_s = 1'b1; ro_s = 1'b1; end
            ADDR_INSTRET:   begin old_s = instret_r[DWIDTH-1:0]; hit_s = 1'b1; ro_s = 1'b1; end
            ADDR_INSTRETH:  begin old_s = hi_word(instret_r);    hit_s = 1'b1; ro_s = 1'b1; end
            default:        begin old_s = {DWIDTH{1'b0}};        hit_s = 1'b0; ro_s = 1'b0; end
        endcase

        case (func[1:0])
            2'b01:   wdata_s = opnd_s;
            2'b10:   wdata_s = old_s | opnd_s;
            2'b11:   wdata_s = old_s & ~opnd_s;
            default: wdata_s = old_s;
        endcase

        wr_eff_s       = wr_req_s && hit_s && !ro_s;
        wr_tohost_s    = wr_eff_s && (addr == ADDR_TOHOST);
        wr_mscratch_s  = wr_eff_s && (addr == ADDR_MSCRATCH);
        wr_mcycle_s    = wr_eff_s && (addr == ADDR_MCYCLE);
        wr_mcycleh_s   = wr_eff_s && (addr == ADDR_MCYCLEH);
        wr_minstret_s  = wr_eff_s && (addr == ADDR_MINSTRET);
        wr_minstreth_s = wr_eff_s && (addr == ADDR_MINSTRETH);

        illegal  = en && (!op_valid_s || !hit_s || (wr_req_s && ro_s));
        data_out = en ? old_s : {DWIDTH{1'b0}};
    end

    // Register file and counters; reset overrides any write or increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mscratch_r  <= {DWIDTH{1'b0}};
            tohost_r    <= {DWIDTH{1'b0}};
            tohost_wr_r <= 1'b0;
            cycle_r     <= {CNT_WIDTH{1'b0}};
            instret_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            if (wr_mscratch_s) begin
                mscratch_r <= wdata_s;
            end
            if (wr_tohost_s) begin
                tohost_r <= wdata_s;
            end
            tohost_wr_r <= wr_tohost_s;
            cycle_r     <= cnt_next(cycle_r, 1'b1, wr_mcycle_s, wr_mcycleh_s, wdata_s);
            instret_r   <= cnt_next(instret_r, retire, wr_minstret_s, wr_minstreth_s, wdata_s);
        end
    end

    assign tohost    = tohost_r;
    assign tohost_wr = tohost_wr_r;

    csr_unit_checker #(.DWIDTH(DWIDTH)) u_checker (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .illegal   (illegal),
        .data_out  (data_out),
        .tohost_wr (tohost_wr)
    );

endmodule

// Interface-level properties of csr_unit.
module csr_unit_checker #(
    parameter int DWIDTH = 32
) (
    input logic              clk,
    input logic              rst,
    input logic              en,
    input logic              illegal,
    input logic [DWIDTH-1:0] data_out,
    input logic              tohost_wr
);

    // Nothing is flagged or read out without a valid instruction.
    a_illegal_needs_en: assert property (@(posedge clk) illegal |-> en);
    a_idle_reads_zero:  assert property (@(posedge clk) !en |-> (data_out == {DWIDTH{1'b0}}));
    // A reset cycle never produces a strobe afterwards.
    a_no_strobe_after_rst: assert property (@(posedge clk) rst |=> !tohost_wr);

endmodule
